disp_scan_driver: RTL and testbench

Upstream stage of the vending machine's seven-segment path. Takes a binary amount (credit or price, 0–9999) and converts it to four BCD digits with an iterative shift-add-3 engine. It then time-multiplexes those digits onto one shared 4-bit digit bus, with an active-low anode select. The 4-bit digit bus feeds the hex-to-seven-segment decoder directly; code 14 is used as the "E" overflow glyph.

---
 rtl/disp_scan_driver_if.sv | 27 ++
 rtl/disp_scan_driver.sv | 138 +++++++++++++
 tb/tb_disp_scan_driver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/disp_scan_driver_if.sv
// rtl/disp_scan_driver_if.sv - load request and multiplexed digit bus of the scan driver
interface disp_scan_driver_if;
    logic [13:0] value;
    logic        load;
    logic [3:0]  digit_code;
    logic [3:0]  anode;
    logic        busy;
    logic        ovf;

    modport master (
        output value,
        output load,
        input  digit_code,
        input  anode,
        input  busy,
        input  ovf
    );

    modport slave (
        input  value,
        input  load,
        output digit_code,
        output anode,
        output busy,
        output ovf
    );
endinterface

// File: rtl/disp_scan_driver.sv
// rtl/disp_scan_driver.sv - binary-to-BCD converter with four-digit time-multiplexed scan
module disp_scan_driver #(
    parameter int DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    disp_scan_driver_if.slave     bus
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [15:0]   bcd_adj;
    logic          ovf_pend_q, ovf_pend_d;
    logic [3:0]    iter_q, iter_d;
    logic          commit;

    logic [3:0]    disp_q [4];
    logic          ovf_q;

    logic [PW-1:0] presc_q;
    logic          presc_wrap;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    anode_q;
    logic [3:0]    digit_q;

    // Add-3 correction on every nibble that would exceed 9 after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 4; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        iter_d     = iter_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    bin_d      = bus.value;
                    bcd_d      = '0;
                    ovf_pend_d = (bus.value > 14'd9999);
                    iter_d     = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                iter_d         = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_pend_q <= 1'b0;
            iter_q     <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            ovf_pend_q <= ovf_pend_d;
            iter_q     <= iter_d;
        end
    end

    // Display registers only move on COMMIT so the scan never shows a partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                disp_q[n] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (commit) begin
            for (int n = 0; n < 4; n++) begin
                disp_q[n] <= ovf_pend_q ? 4'd14 : bcd_q[n*4 +: 4];
            end
            ovf_q <= ovf_pend_q;
        end
    end

    assign presc_wrap = (presc_q == PRESC_LAST);
    assign idx_d      = presc_wrap ? idx_q + 2'd1 : idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
            idx_q   <= idx_d;
        end
    end

    // Anode and code are registered from the same next index, so they switch together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anode_q <= 4'b1110;
            digit_q <= '0;
        end else begin
            anode_q <= ~(4'b0001 << idx_d);
            digit_q <= disp_q[idx_d];
        end
    end

    assign bus.digit_code = digit_q;
    assign bus.anode      = anode_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_disp_scan_driver.sv
// tb/tb_disp_scan_driver.sv - directed checks of conversion, scan and reset behaviour
module tb_disp_scan_driver;

    localparam int DIV = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    disp_scan_driver_if bus ();

    disp_scan_driver #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_load(input logic [13:0] v);
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    // Waits for the conversion to finish, then records one full refresh; nibble i holds digit i.
    task automatic capture(output logic [15:0] d, output logic timed_out);
        int n;
        d         = 16'hFFFF;
        timed_out = 1'b0;
        n         = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) timed_out = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            case (bus.anode)
                4'b1110: d[3:0]   = bus.digit_code;
                4'b1101: d[7:4]   = bus.digit_code;
                4'b1011: d[11:8]  = bus.digit_code;
                4'b0111: d[15:12] = bus.digit_code;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_an;
            exp_an = ~(4'b0001 << i);
            checks++;
            if (bus.anode !== exp_an || bus.digit_code !== 4'd0 || bus.busy !== 1'b0 || bus.ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_scan%0d anode=%b code=%0d busy=%b ovf=%b expected anode=%b code=0 busy=0 ovf=0",
                         i, bus.anode, bus.digit_code, bus.busy, bus.ovf, exp_an);
            end
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic test_convert_1234;
        int n;
        logic [15:0] d;
        logic to;
        do_load(14'd1234);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL busy_len got=%0d expected=15", n);
        end
        capture(d, to);
        checks++;
        if (to || d !== 16'h1234) begin
            errors++;
            $display("FAIL conv_1234 got=%h timeout=%b expected=1234", d, to);
        end
    endtask

    task automatic test_boundaries;
        logic [13:0] vals [4];
        logic [15:0] exps [4];
        logic        ovfs [4];
        logic [15:0] d;
        logic to;
        vals = '{14'd9999, 14'd0, 14'd10000, 14'd5};
        exps = '{16'h9999, 16'h0000, 16'hEEEE, 16'h0005};
        ovfs = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_load(vals[i]);
            capture(d, to);
            checks++;
            if (to || d !== exps[i] || bus.ovf !== ovfs[i]) begin
                errors++;
                $display("FAIL boundary_%0d got=%h ovf=%b timeout=%b expected=%h ovf=%b",
                         vals[i], d, bus.ovf, to, exps[i], ovfs[i]);
            end
        end
    endtask

    task automatic test_ignored_load;
        int busy_cnt;
        int fall_at;
        logic prev_busy;
        logic [15:0] d;
        logic to;
        busy_cnt  = 0;
        fall_at   = -1;
        prev_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (bus.busy) busy_cnt++;
                if (prev_busy && !bus.busy && fall_at < 0) fall_at = i;
                prev_busy = bus.busy;
            end
            bus.load  = (i == 0) || (i == 3);
            bus.value = (i == 3) ? 14'd4321 : 14'd1234;
        end
        bus.load = 1'b0;
        checks++;
        if (busy_cnt != 15 || fall_at != 16) begin
            errors++;
            $display("FAIL ignored_busy count=%0d fall_at=%0d expected count=15 fall_at=16", busy_cnt, fall_at);
        end
        capture(d, to);
        checks++;
        if (to || d !== 16'h1234) begin
            errors++;
            $display("FAIL ignored_value got=%h expected=1234", d);
        end
    endtask

    task automatic test_atomic;
        logic [15:0] d;
        logic to;
        int bad;
        do_load(14'd1111);
        capture(d, to);
        checks++;
        if (to || d !== 16'h1111) begin
            errors++;
            $display("FAIL atomic_pre got=%h expected=1111", d);
        end
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 14'd8000;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            if (bus.digit_code != 4'd1 && bus.digit_code != 4'd8 && bus.digit_code != 4'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL atomic_glitch bad_samples=%0d expected=0", bad);
        end
        capture(d, to);
        checks++;
        if (to || d !== 16'h8000) begin
            errors++;
            $display("FAIL atomic_post got=%h expected=8000", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        logic to;
        do_load(14'd1234);
        // Now just after edge k+1; six more edges reach iteration 6, so the reset lands on iteration 7.
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.anode !== 4'b1110 || bus.digit_code !== 4'd0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%b anode=%b code=%0d ovf=%b expected busy=0 anode=1110 code=0 ovf=0",
                     bus.busy, bus.anode, bus.digit_code, bus.ovf);
        end
        capture(d, to);
        checks++;
        if (to || d !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_disp got=%h expected=0000", d);
        end
        do_load(14'd42);
        capture(d, to);
        checks++;
        if (to || d !== 16'h0042) begin
            errors++;
            $display("FAIL reset_mid_42 got=%h expected=0042", d);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.load  = 1'b0;
        bus.value = '0;
        test_reset();
        test_convert_1234();
        test_boundaries();
        test_ignored_load();
        test_atomic();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
